// File: rtl/video_timing_gen_if.sv
// Video timing bus between the timing generator (master) and the display stage / HDMI encoder side (slave).
// frame_cnt exists only when VIDEO_TIMING_FRAME_CNT_EN is defined.
interface video_timing_gen_if;
    logic [23:0] pixel_data;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;
    logic        frame_start;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        input  pixel_data,
        output data_req,
        output pixel_xpos,
        output pixel_ypos,
        output video_hs,
        output video_vs,
        output video_de,
        output video_rgb,
        output frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output pixel_data,
        input  data_req,
        input  pixel_xpos,
        input  pixel_ypos,
        input  video_hs,
        input  video_vs,
        input  video_de,
        input  video_rgb,
        input  frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/video_timing_gen.sv
// 720p60 video timing generator: free-running H/V counters, one-cycle-early pixel request, aligned registered HS/VS/DE/RGB.
// Optional frame counter output enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen #(
    parameter logic [10:0] H_SYNC  = 11'd40,
    parameter logic [10:0] H_BACK  = 11'd220,
    parameter logic [10:0] H_DISP  = 11'd1280,
    parameter logic [10:0] H_FRONT = 11'd110,
    parameter logic [10:0] V_SYNC  = 11'd5,
    parameter logic [10:0] V_BACK  = 11'd20,
    parameter logic [10:0] V_DISP  = 11'd720,
    parameter logic [10:0] V_FRONT = 11'd5,
    parameter logic        HS_POL  = 1'b1,
    parameter logic        VS_POL  = 1'b1
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    video_timing_gen_if.master  vid
);
    localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] H_START = H_SYNC + H_BACK;
    localparam logic [10:0] V_START = V_SYNC + V_BACK;
    localparam logic [10:0] H_END   = H_START + H_DISP;
    localparam logic [10:0] V_END   = V_START + V_DISP;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        hs_c;
    logic        vs_c;
    logic        v_act_c;
    logic        de_c;
    logic        req_c;
    logic        sof_c;

    // Horizontal/vertical position counters
    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_TOTAL - 11'd1) begin
            h_cnt <= '0;
            if (v_cnt == V_TOTAL - 11'd1) v_cnt <= '0;
            else                          v_cnt <= v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Request window leads the display window by one pixel to cover the display-stage register
    always_comb begin
        hs_c    = (h_cnt < H_SYNC);
        vs_c    = (v_cnt < V_SYNC);
        v_act_c = (v_cnt >= V_START) && (v_cnt < V_END);
        de_c    = v_act_c && (h_cnt >= H_START) && (h_cnt < H_END);
        req_c   = v_act_c && (h_cnt >= H_START - 11'd1) && (h_cnt < H_END - 11'd1);
        sof_c   = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    assign vid.data_req   = req_c;
    assign vid.pixel_xpos = req_c ? h_cnt - (H_START - 11'd1) : 11'd0;
    assign vid.pixel_ypos = req_c ? v_cnt - V_START : 11'd0;

    // Output stage: everything leaves one clock after the counter state that produced it
    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            vid.video_hs    <= ~HS_POL;
            vid.video_vs    <= ~VS_POL;
            vid.video_de    <= 1'b0;
            vid.video_rgb   <= 24'd0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.video_hs    <= hs_c ? HS_POL : ~HS_POL;
            vid.video_vs    <= vs_c ? VS_POL : ~VS_POL;
            vid.video_de    <= de_c;
            vid.video_rgb   <= de_c ? vid.pixel_data : 24'd0;
            vid.frame_start <= sof_c;
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic        first_seen;
    logic [15:0] frame_cnt_q;

    // Counts frames completed since reset; the first frame_start only arms the counter
    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            first_seen  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else if (sof_c) begin
            first_seen <= 1'b1;
            if (first_seen) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster (30x13) so whole frames run quickly.
module tb_video_timing_gen;
    localparam int HSY = 4;
    localparam int HBK = 6;
    localparam int HD  = 16;
    localparam int HFP = 4;
    localparam int VSY = 2;
    localparam int VBK = 3;
    localparam int VD  = 6;
    localparam int VFP = 2;
    localparam int HT  = HSY + HBK + HD + HFP;
    localparam int VT  = VSY + VBK + VD + VFP;
    localparam int HST = HSY + HBK;
    localparam int VST = VSY + VBK;
    localparam int WAIT_MAX = 2000;

    logic pixel_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    initial forever #5 pixel_clk = ~pixel_clk;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_SYNC (11'(HSY)), .H_BACK (11'(HBK)), .H_DISP (11'(HD)), .H_FRONT(11'(HFP)),
        .V_SYNC (11'(VSY)), .V_BACK (11'(VBK)), .V_DISP (11'(VD)), .V_FRONT(11'(VFP)),
        .HS_POL (1'b1), .VS_POL (1'b1)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .vid       (vif)
    );

    typedef struct packed {
        logic        r;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic        fs;
        logic [15:0] fcnt;
    } reg_exp_t;

    typedef struct {
        int          t;
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
    } vec_t;

    reg_exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;
    int t        = 0;

    function automatic logic [23:0] pix(input logic [10:0] x, input logic [10:0] y);
        return {2'b01, y, x};
    endfunction

    function automatic logic m_req(input int tt);
        int h = tt % HT;
        int v = (tt / HT) % VT;
        return (v >= VST) && (v < VST + VD) && (h >= HST - 1) && (h < HST + HD - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        while (t != target && n < WAIT_MAX) begin
            @(negedge pixel_clk);
            n++;
        end
        checks++;
        if (t != target) begin
            failures++;
            $display("FAIL wait_t actual=%0d required=%0d", t, target);
        end
    endtask

    // Reference model: expected registered outputs, pushed on every clock edge
    initial begin
        reg_exp_t e;
        logic [15:0] m_fcnt;
        bit m_seen;
        int h, v;
        bit de;
        m_fcnt = '0;
        m_seen = 1'b0;
        forever begin
            @(posedge pixel_clk);
            if (!sys_rst_n) begin
                e = '{r: 1'b1, hs: 1'b0, vs: 1'b0, de: 1'b0, rgb: 24'd0, fs: 1'b0, fcnt: 16'd0};
                m_fcnt = '0;
                m_seen = 1'b0;
                t = 0;
            end else begin
                h  = t % HT;
                v  = (t / HT) % VT;
                de = (v >= VST) && (v < VST + VD) && (h >= HST) && (h < HST + HD);
                e.r   = 1'b0;
                e.hs  = (h < HSY);
                e.vs  = (v < VSY);
                e.de  = de;
                e.rgb = de ? pix(11'(h - HST), 11'(v - VST)) : 24'd0;
                e.fs  = (h == 0) && (v == 0);
                if (e.fs) begin
                    if (m_seen) m_fcnt = m_fcnt + 16'd1;
                    m_seen = 1'b1;
                end
                e.fcnt = m_fcnt;
                t = t + 1;
            end
            sb_q.push_back(e);
        end
    end

    // Display-stage model plus per-cycle scoreboard and per-frame totals
    initial begin
        reg_exp_t e;
        logic p_req;
        logic [10:0] px, py;
        bit w_valid;
        int w_cyc, w_de, w_hs, w_vs, w_req;
        p_req = 1'b0;
        px = '0;
        py = '0;
        w_valid = 1'b0;
        w_cyc = 0; w_de = 0; w_hs = 0; w_vs = 0; w_req = 0;
        vif.pixel_data = 24'h0;
        @(posedge pixel_clk);
        forever begin
            @(negedge pixel_clk);
            vif.pixel_data = p_req ? pix(px, py) : 24'hA5A5A5;
            p_req = vif.data_req;
            px    = vif.pixel_xpos;
            py    = vif.pixel_ypos;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=0 required=1");
            end else begin
                e = sb_q.pop_front();
                chk("sb_hs",  32'(vif.video_hs),    32'(e.hs));
                chk("sb_vs",  32'(vif.video_vs),    32'(e.vs));
                chk("sb_de",  32'(vif.video_de),    32'(e.de));
                chk("sb_rgb", 32'(vif.video_rgb),   32'(e.rgb));
                chk("sb_fs",  32'(vif.frame_start), 32'(e.fs));
`ifdef VIDEO_TIMING_FRAME_CNT_EN
                chk("sb_fcnt", 32'(vif.frame_cnt), 32'(e.fcnt));
`endif
                chk("sb_req", 32'(vif.data_req), 32'(m_req(t)));
                chk("sb_xpos", 32'(vif.pixel_xpos),
                    m_req(t) ? 32'((t % HT) - (HST - 1)) : 32'd0);
                chk("sb_ypos", 32'(vif.pixel_ypos),
                    m_req(t) ? 32'(((t / HT) % VT) - VST) : 32'd0);
                if (e.r) w_valid = 1'b0;
                if (vif.frame_start === 1'b1) begin
                    if (w_valid) begin
                        chk("frame_cycles", 32'(w_cyc), 32'(HT * VT));
                        chk("frame_de",     32'(w_de),  32'(HD * VD));
                        chk("frame_req",    32'(w_req), 32'(HD * VD));
                        chk("frame_hs",     32'(w_hs),  32'(HSY * VT));
                        chk("frame_vs",     32'(w_vs),  32'(VSY * HT));
                    end
                    w_valid = 1'b1;
                    w_cyc = 0; w_de = 0; w_hs = 0; w_vs = 0; w_req = 0;
                end
                w_cyc++;
                if (vif.video_de === 1'b1) w_de++;
                if (vif.video_hs === 1'b1) w_hs++;
                if (vif.video_vs === 1'b1) w_vs++;
                if (vif.data_req === 1'b1) w_req++;
            end
        end
    end

    // Main sequence: reset hold, table of timing checkpoints, mid-frame reset, frame counting
    initial begin
        vec_t tab[16];
        tab[0]  = '{1,   1'b0, 11'd0,  11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0};
        tab[1]  = '{2,   1'b0, 11'd0,  11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
        tab[2]  = '{5,   1'b0, 11'd0,  11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
        tab[3]  = '{129, 1'b0, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[4]  = '{159, 1'b1, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[5]  = '{160, 1'b1, 11'd1,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[6]  = '{161, 1'b1, 11'd2,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h400000};
        tab[7]  = '{174, 1'b1, 11'd15, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h40000D};
        tab[8]  = '{175, 1'b0, 11'd0,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h40000E};
        tab[9]  = '{176, 1'b0, 11'd0,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h40000F};
        tab[10] = '{177, 1'b0, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[11] = '{309, 1'b1, 11'd0,  11'd5, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[12] = '{339, 1'b0, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[13] = '{390, 1'b0, 11'd0,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
        tab[14] = '{391, 1'b0, 11'd0,  11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0};
        tab[15] = '{451, 1'b0, 11'd0,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};

        sys_rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pixel_clk);
            chk("rst_de",  32'(vif.video_de),  32'd0);
            chk("rst_rgb", 32'(vif.video_rgb), 32'd0);
            chk("rst_hs",  32'(vif.video_hs),  32'd0);
            chk("rst_vs",  32'(vif.video_vs),  32'd0);
            chk("rst_req", 32'(vif.data_req),  32'd0);
        end
        sys_rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wait_t(tab[i].t);
            chk("tab_req",  32'(vif.data_req),    32'(tab[i].req));
            chk("tab_xpos", 32'(vif.pixel_xpos),  32'(tab[i].x));
            chk("tab_ypos", 32'(vif.pixel_ypos),  32'(tab[i].y));
            chk("tab_de",   32'(vif.video_de),    32'(tab[i].de));
            chk("tab_hs",   32'(vif.video_hs),    32'(tab[i].hs));
            chk("tab_vs",   32'(vif.video_vs),    32'(tab[i].vs));
            chk("tab_fs",   32'(vif.frame_start), 32'(tab[i].fs));
            chk("tab_rgb",  32'(vif.video_rgb),   32'(tab[i].rgb));
        end

        // One-cycle reset in the middle of an active line (frame 2, v=7, h=15)
        wait_t(615);
        chk("pre_rst_de", 32'(vif.video_de), 32'd1);
        sys_rst_n = 1'b0;
        @(negedge pixel_clk);
        chk("mid_rst_de",  32'(vif.video_de),    32'd0);
        chk("mid_rst_rgb", 32'(vif.video_rgb),   32'd0);
        chk("mid_rst_req", 32'(vif.data_req),    32'd0);
        chk("mid_rst_x",   32'(vif.pixel_xpos),  32'd0);
        chk("mid_rst_hs",  32'(vif.video_hs),    32'd0);
        chk("mid_rst_fs",  32'(vif.frame_start), 32'd0);
        sys_rst_n = 1'b1;

        wait_t(1);
        chk("restart_fs", 32'(vif.frame_start), 32'd1);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        chk("fcnt_0", 32'(vif.frame_cnt), 32'd0);
`endif
        wait_t(120);
        chk("restart_v4_de", 32'(vif.video_de), 32'd0);
        wait_t(159);
        chk("restart_req",  32'(vif.data_req),   32'd1);
        chk("restart_ypos", 32'(vif.pixel_ypos), 32'd0);
        wait_t(161);
        chk("restart_de",  32'(vif.video_de),  32'd1);
        chk("restart_rgb", 32'(vif.video_rgb), 32'h400000);
        wait_t(391);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        chk("fcnt_1", 32'(vif.frame_cnt), 32'd1);
`endif
        chk("fs_2", 32'(vif.frame_start), 32'd1);
        wait_t(781);
        chk("fs_3", 32'(vif.frame_start), 32'd1);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        chk("fcnt_2", 32'(vif.frame_cnt), 32'd2);
`endif
        wait_t(790);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- 720p60 video timing generator; sits directly upstream of the colour-bar / pattern display stage on the HDMI output path.
- Runs free-running horizontal and vertical counters and issues pixel coordinates plus a data request one cycle ahead of the active window.
- Registers the returned 24-bit pixel data together with HS/VS/DE so all video outputs reach the HDMI encoder aligned.

Parameters:
H_SYNC, 11'd40, horizontal sync width (pixels)
H_BACK, 11'd220, horizontal back porch
H_DISP, 11'd1280, horizontal active pixels
H_FRONT, 11'd110, horizontal front porch
V_SYNC, 11'd5, vertical sync width (lines)
V_BACK, 11'd20, vertical back porch
V_DISP, 11'd720, vertical active lines
V_FRONT, 11'd5, vertical front porch
HS_POL, 1'b1, HS active level (1 = active high)
VS_POL, 1'b1, VS active level

Ports:
pixel_clk  in  1  pixel clock (74.25 MHz for 720p60)
sys_rst_n  in  1  reset, synchronous, active-low
pixel_data  in  24  RGB888 from display stage; sampled one cycle after data_req
data_req  out  1  request for the pixel at (pixel_xpos, pixel_ypos)
pixel_xpos  out  11  requested column, 0..H_DISP-1; 0 when data_req low
pixel_ypos  out  11  requested row, 0..V_DISP-1; 0 when data_req low
video_hs  out  1  horizontal sync, registered
video_vs  out  1  vertical sync, registered
video_de  out  1  data enable, registered
video_rgb  out  24  output pixel, registered; 0 outside active window
frame_start  out  1  one-cycle pulse, registered, first cycle of each frame

Behaviour:
- Derived values: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (1650); V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (750); H_START = H_SYNC+H_BACK (260); V_START = V_SYNC+V_BACK (25).
- Reset: sys_rst_n sampled on the pixel_clk rising edge; synchronous, active-low.
  - h_cnt=0, v_cnt=0.
  - video_hs=~HS_POL, video_vs=~VS_POL, video_de=0, video_rgb=0, frame_start=0.
  - data_req=0, pixel_xpos=0, pixel_ypos=0 (decoded from counters, so they follow the counter reset).
  - Reset asserted mid-line or mid-frame: all of the above take these values on the next edge. On release, counting restarts at h_cnt=0, v_cnt=0; no partial frame is resumed.
- Counters, 11-bit:
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only in the cycle h_cnt wraps. It wraps V_TOTAL-1 -> 0 when h_cnt and v_cnt wrap in the same cycle.
- Combinational decode from the counter registers:
  - hs_c = (h_cnt < H_SYNC)
  - vs_c = (v_cnt < V_SYNC)
  - v_act = (V_START <= v_cnt < V_START+V_DISP)
  - de_c = v_act && (H_START <= h_cnt < H_START+H_DISP)
  - data_req = v_act && (H_START-1 <= h_cnt < H_START+H_DISP-1)
  - pixel_xpos = data_req ? h_cnt-(H_START-1) : 0
  - pixel_ypos = data_req ? v_cnt-V_START : 0
- Output register stage, updated every edge:
  - video_hs <= hs_c ? HS_POL : ~HS_POL; video_vs likewise with vs_c and VS_POL.
  - video_de <= de_c.
  - video_rgb <= de_c ? pixel_data : 24'd0.
  - frame_start <= (h_cnt==0 && v_cnt==0).
- Latency and contract with the display stage:
  - The display stage must register pixel_data exactly one cycle after seeing the coordinates.
  - The pixel for xpos=N is presented while h_cnt=H_START+N and is captured into video_rgb at the end of that cycle.
  - video_rgb, video_de, video_hs and video_vs are therefore mutually aligned, each one pixel_clk after the counter state that produced it.
- Per active line: data_req high exactly H_DISP consecutive cycles; video_de high exactly H_DISP consecutive cycles.
- Per frame: V_DISP active lines; HS pulse width H_SYNC cycles every line; VS pulse width V_SYNC lines, with VS edges coincident with HS leading edges.
- pixel_data outside de_c is ignored.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0].
  - Reset value 0; increments by 1 on each cycle frame_start is driven high, except the first frame_start after reset release.
  - Wraps 16'hFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Hold sys_rst_n=0 for 10 cycles -> video_de=0, video_rgb=0, video_hs=0, video_vs=0 (POL=1), data_req=0 throughout; first frame_start pulse 1 cycle after release.
- Free-run one line with pixel_data = {13'd0, pixel_xpos} delayed one cycle -> data_req first high at h_cnt=259 with xpos=0; video_de high 1280 cycles; video_rgb on the first DE cycle = 0 and on the last = 1279.
- Run one full frame -> 1650*750 = 1237500 cycles between frame_start pulses; video_hs high 40 cycles per line; video_vs high 5*1650 = 8250 cycles; 720 DE bursts.
- Line 24 vs line 25 -> no data_req on v_cnt=24; v_cnt=25 gives pixel_ypos=0; last active line gives pixel_ypos=719; data_req never asserts for v_cnt in 745..749.
- Assert sys_rst_n=0 for 1 cycle at h_cnt=800, v_cnt=300 (mid-DE) -> video_de and video_rgb drop to 0 on the next edge; after release h_cnt restarts at 0 and the next DE occurs at v_cnt=25.
- With VIDEO_TIMING_FRAME_CNT_EN defined, run 3 frames after reset -> frame_cnt steps 0->1->2 at the 2nd and 3rd frame_start pulses.
